// File: rtl/mem_arbiter.sv
// Arbiter that shares one variable-latency memory port between instruction fetch and data access.
// Data has priority over fetch, limited by a streak counter. Define ARB_TIMEOUT_EN to add a MemAck watchdog and the BusErr flag.
module mem_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IReq,
   input  logic [AW-1:0] IAddr,
   output logic          IRdy,
   output logic [DW-1:0] IRData,
   input  logic          DReq,
   input  logic          DWe,
   input  logic [AW-1:0] DAddr,
   input  logic [DW-1:0] DWData,
   output logic          DRdy,
   output logic [DW-1:0] DRData,
   output logic          MemReq,
   output logic          MemWe,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   input  logic          MemAck,
   input  logic [DW-1:0] MemRData,
   output logic          Stall,
   output logic          BusErr
);

   // state  | meaning
   // IDLE   | arbitrate on IReq/DReq
   // BUSY_I | fetch access outstanding, waiting for MemAck
   // BUSY_D | data access outstanding, waiting for MemAck
   // RESP_I | IRdy pulse; requests are not sampled here
   // RESP_D | DRdy pulse; requests are not sampled here
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_I = 3'd1,
      BUSY_D = 3'd2,
      RESP_I = 3'd3,
      RESP_D = 3'd4
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

   state_t     state;
   state_t     state_next;
   logic [3:0] dstreak;
   logic       grant_d;
   logic       grant_i;
   logic       busy;
   logic       wd_hit;
   logic       leave_busy;

   assign busy       = (state == BUSY_I) || (state == BUSY_D);
   assign leave_busy = busy && (MemAck || wd_hit);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      case (state)
         IDLE: begin
            if (DReq && !(IReq && (dstreak == STREAK_MAX))) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end else if (IReq) begin
               grant_i    = 1'b1;
               state_next = BUSY_I;
            end
         end
         BUSY_I: begin
            if (MemAck || wd_hit) state_next = RESP_I;
         end
         BUSY_D: begin
            if (MemAck || wd_hit) state_next = RESP_D;
         end
         RESP_I, RESP_D: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         MemReq   <= 1'b0;
         MemWe    <= 1'b0;
         MemAddr  <= '0;
         MemWData <= '0;
         IRData   <= '0;
         DRData   <= '0;
         dstreak  <= 4'd0;
      end else begin
         if (grant_d) begin
            MemReq   <= 1'b1;
            MemWe    <= DWe;
            MemAddr  <= DAddr;
            MemWData <= DWData;
            if (!IReq) begin
               dstreak <= 4'd0;
            end else if (dstreak != STREAK_MAX) begin
               dstreak <= dstreak + 4'd1;
            end
         end else if (grant_i) begin
            MemReq  <= 1'b1;
            MemWe   <= 1'b0;
            MemAddr <= IAddr;
            dstreak <= 4'd0;
         end

         if (leave_busy) MemReq <= 1'b0;

         if (busy && MemAck) begin
            if (state == BUSY_I) begin
               IRData <= MemRData;
            end else if (!MemWe) begin
               DRData <= MemRData;
            end
         end
`ifdef ARB_TIMEOUT_EN
         else if (busy && wd_hit) begin
            if (state == BUSY_I) begin
               IRData <= DW'(32'hDEADBEEF);
            end else if (!MemWe) begin
               DRData <= DW'(32'hDEADBEEF);
            end
         end
`endif
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt;

   assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wd_cnt <= '0;
         BusErr <= 1'b0;
      end else begin
         if (grant_d || grant_i) begin
            wd_cnt <= '0;
         end else if (busy && !wd_hit) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         // sticky until reset
         if (busy && wd_hit && !MemAck) BusErr <= 1'b1;
      end
   end
`else
   logic unused_timeout_param;

   assign unused_timeout_param = (TIMEOUT > 0);
   assign wd_hit               = 1'b0;
   assign BusErr               = 1'b0;
`endif

   assign IRdy  = (state == RESP_I);
   assign DRdy  = (state == RESP_D);
   assign Stall = (IReq && !IRdy) || (DReq && !DRdy);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, collision, starvation limit, zero-wait, mid-access reset.
// Covers the watchdog when ARB_TIMEOUT_EN is defined, and the wait-forever behaviour otherwise.
module tb_mem_arbiter;

   logic        CLK;
   logic        RST;
   logic        IReq;
   logic [31:0] IAddr;
   logic        IRdy;
   logic [31:0] IRData;
   logic        DReq;
   logic        DWe;
   logic [31:0] DAddr;
   logic [31:0] DWData;
   logic        DRdy;
   logic [31:0] DRData;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic        MemAck;
   logic [31:0] MemRData;
   logic        Stall;
   logic        BusErr;

   int checks = 0;
   int passes = 0;

   mem_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(4), .TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST),
      .IReq(IReq), .IAddr(IAddr), .IRdy(IRdy), .IRData(IRData),
      .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
      .DRdy(DRdy), .DRData(DRData),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemAck(MemAck), .MemRData(MemRData),
      .Stall(Stall), .BusErr(BusErr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL sim_time_limit: got no finish, want finish before 200000");
      $fatal(1);
   end

   task automatic test_reset();
      RST = 1'b1; IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWe = 1'b0; DAddr = '0; DWData = '0;
      MemAck = 1'b0; MemRData = '0;
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (MemReq !== 1'b0) $display("FAIL rst_memreq: got %0h want 0", MemReq); else passes++;
      checks++; if (MemWe !== 1'b0) $display("FAIL rst_memwe: got %0h want 0", MemWe); else passes++;
      checks++; if (MemAddr !== 32'h0) $display("FAIL rst_memaddr: got %0h want 0", MemAddr); else passes++;
      checks++; if (MemWData !== 32'h0) $display("FAIL rst_memwdata: got %0h want 0", MemWData); else passes++;
      checks++; if ({IRdy, DRdy} !== 2'b00) $display("FAIL rst_rdy: got %0b want 00", {IRdy, DRdy}); else passes++;
      checks++; if (IRData !== 32'h0 || DRData !== 32'h0) $display("FAIL rst_rdata: got %0h/%0h want 0/0", IRData, DRData); else passes++;
      checks++; if (Stall !== 1'b0) $display("FAIL rst_stall: got %0h want 0", Stall); else passes++;
      checks++; if (BusErr !== 1'b0) $display("FAIL rst_buserr: got %0h want 0", BusErr); else passes++;
      RST = 1'b0;
   endtask

   task automatic test_single_fetch();
      IReq = 1'b1; IAddr = 32'h100;
      @(negedge CLK);
      checks++; if (MemReq !== 1'b1) $display("FAIL fetch_memreq_c1: got %0h want 1", MemReq); else passes++;
      checks++; if (MemAddr !== 32'h100) $display("FAIL fetch_memaddr: got %0h want 100", MemAddr); else passes++;
      checks++; if (MemWe !== 1'b0) $display("FAIL fetch_memwe: got %0h want 0", MemWe); else passes++;
      checks++; if (Stall !== 1'b1) $display("FAIL fetch_stall_c1: got %0h want 1", Stall); else passes++;
      @(negedge CLK);
      checks++; if (MemReq !== 1'b1) $display("FAIL fetch_memreq_c2: got %0h want 1", MemReq); else passes++;
      @(negedge CLK);
      checks++; if (MemReq !== 1'b1 || IRdy !== 1'b0) $display("FAIL fetch_c3: got memreq %0h irdy %0h want 1 0", MemReq, IRdy); else passes++;
      MemAck = 1'b1; MemRData = 32'h8C220004;
      @(negedge CLK);
      checks++; if (IRdy !== 1'b1) $display("FAIL fetch_irdy_c4: got %0h want 1", IRdy); else passes++;
      checks++; if (IRData !== 32'h8C220004) $display("FAIL fetch_irdata: got %0h want 8c220004", IRData); else passes++;
      checks++; if (MemReq !== 1'b0) $display("FAIL fetch_memreq_c4: got %0h want 0", MemReq); else passes++;
      checks++; if (Stall !== 1'b0) $display("FAIL fetch_stall_c4: got %0h want 0", Stall); else passes++;
      MemAck = 1'b0; IReq = 1'b0;
      @(negedge CLK);
      checks++; if (IRdy !== 1'b0 || Stall !== 1'b0) $display("FAIL fetch_c5: got irdy %0h stall %0h want 0 0", IRdy, Stall); else passes++;
   endtask

   task automatic test_collision();
      IReq = 1'b1; IAddr = 32'h200;
      DReq = 1'b1; DWe = 1'b1; DAddr = 32'h40; DWData = 32'h55;
      @(negedge CLK);
      checks++; if (MemWe !== 1'b1 || MemAddr !== 32'h40) $display("FAIL coll_data_first: got we %0h addr %0h want 1 40", MemWe, MemAddr); else passes++;
      checks++; if (MemWData !== 32'h55) $display("FAIL coll_wdata: got %0h want 55", MemWData); else passes++;
      MemAck = 1'b1; MemRData = 32'hCAFE;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b1 || IRdy !== 1'b0) $display("FAIL coll_drdy_first: got drdy %0h irdy %0h want 1 0", DRdy, IRdy); else passes++;
      checks++; if (DRData !== 32'h0) $display("FAIL coll_store_holds_drdata: got %0h want 0", DRData); else passes++;
      MemAck = 1'b0; DReq = 1'b0; DWe = 1'b0;
      @(negedge CLK);
      checks++; if (MemReq !== 1'b0 || Stall !== 1'b1) $display("FAIL coll_idle: got memreq %0h stall %0h want 0 1", MemReq, Stall); else passes++;
      @(negedge CLK);
      checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h200 || MemWe !== 1'b0) $display("FAIL coll_fetch_grant: got req %0h addr %0h we %0h want 1 200 0", MemReq, MemAddr, MemWe); else passes++;
      MemAck = 1'b1; MemRData = 32'h1234;
      @(negedge CLK);
      checks++; if (IRdy !== 1'b1 || IRData !== 32'h1234) $display("FAIL coll_irdy: got irdy %0h data %0h want 1 1234", IRdy, IRData); else passes++;
      MemAck = 1'b0; IReq = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_starvation();
      IReq = 1'b1; IAddr = 32'h300;
      DReq = 1'b1; DWe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         DAddr = 32'h80 + 32'(4 * i);
         @(negedge CLK);
         checks++; if (MemAddr !== 32'h80 + 32'(4 * i) || Stall !== 1'b1) $display("FAIL starve_data_grant%0d: got addr %0h stall %0h want %0h 1", i, MemAddr, Stall, 32'h80 + 32'(4 * i)); else passes++;
         MemAck = 1'b1; MemRData = 32'hA0 + 32'(i);
         @(negedge CLK);
         checks++; if (DRdy !== 1'b1 || DRData !== 32'hA0 + 32'(i)) $display("FAIL starve_drdy%0d: got drdy %0h data %0h want 1 %0h", i, DRdy, DRData, 32'hA0 + 32'(i)); else passes++;
         MemAck = 1'b0;
         @(negedge CLK);
      end
      DAddr = 32'h8C;
      @(negedge CLK);
      checks++; if (MemAddr !== 32'h300 || MemWe !== 1'b0) $display("FAIL starve_fetch_after_4: got addr %0h we %0h want 300 0", MemAddr, MemWe); else passes++;
      MemAck = 1'b1; MemRData = 32'h77;
      @(negedge CLK);
      checks++; if (IRdy !== 1'b1 || DRdy !== 1'b0 || IRData !== 32'h77) $display("FAIL starve_irdy: got irdy %0h drdy %0h data %0h want 1 0 77", IRdy, DRdy, IRData); else passes++;
      MemAck = 1'b0; IAddr = 32'h304;
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (MemAddr !== 32'h8C) $display("FAIL starve_streak_cleared: got addr %0h want 8c", MemAddr); else passes++;
      MemAck = 1'b1; MemRData = 32'h99;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b1 || DRData !== 32'h99) $display("FAIL starve_drdy_after: got drdy %0h data %0h want 1 99", DRdy, DRData); else passes++;
      MemAck = 1'b0; DReq = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (MemAddr !== 32'h304) $display("FAIL starve_final_fetch: got addr %0h want 304", MemAddr); else passes++;
      MemAck = 1'b1; MemRData = 32'h305;
      @(negedge CLK);
      MemAck = 1'b0; IReq = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h10;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b0 || MemReq !== 1'b1) $display("FAIL b2b_c1: got drdy %0h memreq %0h want 0 1", DRdy, MemReq); else passes++;
      MemAck = 1'b1; MemRData = 32'h11;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b1 || DRData !== 32'h11) $display("FAIL b2b_first_rdy_c2: got drdy %0h data %0h want 1 11", DRdy, DRData); else passes++;
      MemAck = 1'b0; DAddr = 32'h14;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b0 || MemReq !== 1'b0) $display("FAIL b2b_c3_idle: got drdy %0h memreq %0h want 0 0", DRdy, MemReq); else passes++;
      MemAck = 1'b1; MemRData = 32'hBAD;
      @(negedge CLK);
      checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h14 || DRData !== 32'h11) $display("FAIL b2b_stray_ack_ignored: got req %0h addr %0h data %0h want 1 14 11", MemReq, MemAddr, DRData); else passes++;
      MemRData = 32'h15;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b1 || DRData !== 32'h15) $display("FAIL b2b_second_rdy_c5: got drdy %0h data %0h want 1 15", DRdy, DRData); else passes++;
      MemAck = 1'b0; DReq = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset_mid();
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h20;
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (MemReq !== 1'b1) $display("FAIL rstmid_busy: got memreq %0h want 1", MemReq); else passes++;
      RST = 1'b1;
      #1;
      checks++; if (MemReq !== 1'b0 || MemAddr !== 32'h0) $display("FAIL rstmid_async_drop: got req %0h addr %0h want 0 0", MemReq, MemAddr); else passes++;
      checks++; if (DRData !== 32'h0) $display("FAIL rstmid_drdata: got %0h want 0", DRData); else passes++;
      @(negedge CLK);
      RST = 1'b0; DReq = 1'b0;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b0 || MemReq !== 1'b0) $display("FAIL rstmid_no_rdy: got drdy %0h req %0h want 0 0", DRdy, MemReq); else passes++;
      DReq = 1'b1; DAddr = 32'h24;
      @(negedge CLK);
      checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h24) $display("FAIL rstmid_new_grant: got req %0h addr %0h want 1 24", MemReq, MemAddr); else passes++;
      MemAck = 1'b1; MemRData = 32'h25;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b1 || DRData !== 32'h25) $display("FAIL rstmid_new_rdy: got drdy %0h data %0h want 1 25", DRdy, DRData); else passes++;
      MemAck = 1'b0; DReq = 1'b0;
      @(negedge CLK);
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h44;
      n = 0;
      @(negedge CLK);
      while (MemReq === 1'b1 && n < 20) begin
         n++;
         @(negedge CLK);
      end
      checks++; if (n !== 8) $display("FAIL tmo_busy_cycles: got %0d want 8", n); else passes++;
      checks++; if (DRdy !== 1'b1 || DRData !== 32'hDEADBEEF) $display("FAIL tmo_rdy_data: got drdy %0h data %0h want 1 deadbeef", DRdy, DRData); else passes++;
      checks++; if (BusErr !== 1'b1) $display("FAIL tmo_buserr_set: got %0h want 1", BusErr); else passes++;
      DReq = 1'b0;
      @(negedge CLK);
      IReq = 1'b1; IAddr = 32'h50;
      @(negedge CLK);
      MemAck = 1'b1; MemRData = 32'h51;
      @(negedge CLK);
      checks++; if (IRdy !== 1'b1 || IRData !== 32'h51 || BusErr !== 1'b1) $display("FAIL tmo_sticky: got irdy %0h data %0h buserr %0h want 1 51 1", IRdy, IRData, BusErr); else passes++;
      MemAck = 1'b0; IReq = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      checks++; if (BusErr !== 1'b0) $display("FAIL tmo_buserr_reset: got %0h want 0", BusErr); else passes++;
      @(negedge CLK);
      RST = 1'b0;
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h48;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (MemReq !== 1'b1 || DRdy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL notmo_waits: got %0d bad cycles want 0", bad); else passes++;
      MemAck = 1'b1; MemRData = 32'h49;
      @(negedge CLK);
      checks++; if (DRdy !== 1'b1 || DRData !== 32'h49 || BusErr !== 1'b0) $display("FAIL notmo_late_ack: got drdy %0h data %0h buserr %0h want 1 49 0", DRdy, DRData, BusErr); else passes++;
      MemAck = 1'b0; DReq = 1'b0;
      @(negedge CLK);
   endtask
`endif

   initial begin
      test_reset();
      test_single_fetch();
      test_collision();
      test_starvation();
      test_back_to_back();
      test_reset_mid();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified, variable-latency memory port between the core's instruction-fetch requester (read-only) and data-access requester (load/store).
- Sits between core (PC/Instr, ALUOut/WriteData/ReadData/MemRead/MemWrite) and the single memory.
- Fixed data-over-fetch priority with a starvation limiter.
- Produces a Stall signal that freezes the core until its outstanding accesses complete.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAX_DSTREAK, 4, maximum consecutive data grants while a fetch is pending (range 1..15).
- TIMEOUT, 64, cycles to wait for MemAck before BusErr (used only with ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IReq  in  1  fetch request; held high with IAddr stable until IRdy.
- IAddr  in  AW  fetch address.
- IRdy  out  1  one-cycle pulse; IRData valid in the same cycle.
- IRData  out  DW  fetched word, registered.
- DReq  in  1  data request; held high with DWe/DAddr/DWData stable until DRdy.
- DWe  in  1  1 = store, 0 = load.
- DAddr  in  AW  data address.
- DWData  in  DW  store data.
- DRdy  out  1  one-cycle completion pulse.
- DRData  out  DW  load data, registered; holds last value on stores.
- MemReq  out  1  memory request, registered.
- MemWe  out  1  memory write enable, registered.
- MemAddr  out  AW  memory address, registered.
- MemWData  out  DW  memory write data, registered.
- MemAck  in  1  one-cycle acknowledge from memory.
- MemRData  in  DW  memory read data, valid with MemAck.
- Stall  out  1  combinational: (IReq & ~IRdy) | (DReq & ~DRdy).
- BusErr  out  1  sticky timeout flag (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Asynchronous, active-high reset. On reset:
  - state = IDLE.
  - MemReq, MemWe, IRdy, DRdy = 0.
  - MemAddr, MemWData, IRData, DRData = 0.
  - DStreak counter = 0; BusErr = 0.
- Reset mid-transaction abandons the access immediately; MemReq drops asynchronously and the requester gets no Rdy.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - Arbitrate on the current IReq/DReq.
  - Winner is data if DReq and not (IReq and DStreak == MAX_DSTREAK); else fetch if IReq; else stay in IDLE.
  - On grant, latch the winner's address, write data and We into the Mem* registers (MemWe = 0 for fetch).
  - Set MemReq = 1 and go to BUSY_x. MemReq is therefore high from the cycle after grant.
- BUSY_x:
  - Hold MemReq and all Mem* outputs stable.
  - On MemAck: capture MemRData into IRData (BUSY_I), or into DRData if not a store (BUSY_D).
  - Then clear MemReq and go to RESP_x.
  - No MemAck: stay in BUSY_x indefinitely (unless timeout is enabled).
- RESP_x:
  - Pulse IRdy or DRdy for exactly one cycle, then go to IDLE.
  - The requester drops Req in the following cycle. The arbiter never samples a requester's Req in its RESP cycle, so a completed request is not re-granted.
- Latency: Req seen in IDLE at cycle 0; MemReq at cycle 1; MemAck at cycle k ≥ 1; Rdy at cycle k+1. Minimum 2 cycles; one access per 3 cycles at best.
- DStreak:
  - Increments on a data grant while IReq is high; saturates at MAX_DSTREAK.
  - Clears on a fetch grant.
  - Clears on a data grant while IReq is low.
- Simultaneous IReq and DReq with DStreak < MAX_DSTREAK: data wins.
- MemAck outside BUSY_x is ignored.
- Requests arriving while busy wait; there are no queues.
- Read data registers update only on the owning MemAck.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to BUSY_x and increments every BUSY cycle.
  - When it reaches TIMEOUT without MemAck: set BusErr (sticky until RST), drop MemReq, go to RESP_x and pulse Rdy.
  - Returned data on timeout = 32'hDEADBEEF (DW-wide pattern, truncated/zero-extended).
- Not defined: no counter logic, BusErr tied 0, BUSY waits forever.

Test Plan:
- Single fetch: IReq = 1, IAddr = 0x100 at c0; memory acks c3 with 0x8C220004 -> MemReq c1–c3, MemAddr = 0x100, MemWe = 0, IRdy and IRData = 0x8C220004 at c4, Stall low at c5.
- Collision: IReq and DReq (store, DAddr = 0x40, DWData = 0x55) at c0 -> data granted first: MemWe = 1, MemAddr = 0x40; DRdy precedes IRdy; fetch granted in the IDLE after RESP_D.
- Starvation: IReq held, DReq re-asserted after every DRdy, MAX_DSTREAK = 4 -> exactly 4 data grants, then a fetch grant; DStreak returns to 0.
- Zero-wait memory: MemAck in the first cycle MemReq is high -> Rdy exactly 2 cycles after Req; back-to-back loads complete every 3 cycles.
- Reset mid-access: RST pulsed during BUSY_D -> MemReq low immediately, no DRdy, IDLE afterward; a new DReq is served normally.
- ARB_TIMEOUT_EN, TIMEOUT = 8, no MemAck -> MemReq drops after 8 BUSY cycles, BusErr = 1, DRdy with 0xDEADBEEF; BusErr stays 1 until RST.
